// File: rtl/rtc_escritor_fecha_if.sv
// RTC parallel bus (multiplexed address/data) between the date writer and the
// top-level tri-state pads.
//   cs_n    : chip select, active low
//   rd_n    : read strobe, active low (the writer keeps it high)
//   wr_n    : write strobe, active low
//   a_d     : phase select, 0 = address, 1 = data
//   bus_out : value to drive on the AD bus
//   bus_oe  : output enable for the AD bus pads
interface rtc_escritor_fecha_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] bus_out;
  logic       bus_oe;

  modport master (
    output cs_n, rd_n, wr_n, a_d, bus_out, bus_oe
  );

  modport slave (
    input cs_n, rd_n, wr_n, a_d, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_escritor_fecha.sv
// Writes the configured date (day, month, year in packed BCD) into the external
// RTC as three address/data write transactions on its multiplexed bus.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : one-cycle request, sampled only when idle
//   dia/mes/anio_bcd      : date fields, BCD {tens,units}
//   ocupado               : high whenever a request is in progress
//   listo                 : one-cycle pulse after the third write
//   error_dato            : sticky invalid-date flag, cleared on next accepted start
//   rtc                   : RTC bus (master side)
module rtc_escritor_fecha #(
  parameter int unsigned T_PH      = 10,
  parameter int unsigned T_GAP     = 5,
  parameter logic [7:0]  ADDR_DIA  = 8'h24,
  parameter logic [7:0]  ADDR_MES  = 8'h25,
  parameter logic [7:0]  ADDR_ANIO = 8'h26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           dia_bcd,
  input  logic [7:0]           mes_bcd,
  input  logic [7:0]           anio_bcd,
  output logic                 ocupado,
  output logic                 listo,
  output logic                 error_dato,
  rtc_escritor_fecha_if.master rtc
);

  localparam int unsigned T_MAX = (T_PH > T_GAP) ? T_PH : T_GAP;
  localparam int unsigned CW    = $clog2(T_MAX) + 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(T_PH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADR_WR,
    S_ADR_HOLD,
    S_DAT_WR,
    S_DAT_HOLD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    k_q, k_d;
  logic [7:0]    dia_q, dia_d, mes_q, mes_d, anio_q, anio_d;
  logic          err_q, err_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q;
  logic          wr_n_q, wr_n_d;
  logic          a_d_q, a_d_d;
  logic [7:0]    bus_out_q, bus_out_d;
  logic          bus_oe_q, bus_oe_d;
  logic          fields_ok_c;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] addr_of(input logic [1:0] k);
    case (k)
      2'd0:    return ADDR_DIA;
      2'd1:    return ADDR_MES;
      default: return ADDR_ANIO;
    endcase
  endfunction

  // Valid BCD nibbles make a plain byte compare equal to a decimal range check.
  assign fields_ok_c = bcd_ok(dia_q) && bcd_ok(mes_q) && bcd_ok(anio_q) &&
                       (dia_q != 8'h00) && (dia_q <= 8'h31) &&
                       (mes_q != 8'h00) && (mes_q <= 8'h12);

  // Next state, then outputs decoded from the next state so they are registered
  // in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    k_d       = k_q;
    dia_d     = dia_q;
    mes_d     = mes_q;
    anio_d    = anio_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          dia_d   = dia_bcd;
          mes_d   = mes_bcd;
          anio_d  = anio_bcd;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (fields_ok_c) begin
          k_d     = 2'd0;
          state_d = S_ADR_WR;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ADR_WR: begin
        if (cnt_q == PH_LAST) begin
          cnt_d   = '0;
          state_d = S_ADR_HOLD;
        end
      end
      S_ADR_HOLD: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_DAT_WR;
        end
      end
      S_DAT_WR: begin
        if (cnt_q == PH_LAST) begin
          cnt_d   = '0;
          state_d = S_DAT_HOLD;
        end
      end
      S_DAT_HOLD: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (k_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_ADR_WR;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    ocupado_d = (state_d != S_IDLE);
    listo_d   = (state_d == S_DONE);
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    a_d_d     = 1'b0;
    bus_out_d = 8'h00;
    bus_oe_d  = 1'b0;

    case (state_d)
      S_ADR_WR, S_ADR_HOLD: begin
        cs_n_d    = 1'b0;
        wr_n_d    = (state_d == S_ADR_HOLD);
        bus_oe_d  = 1'b1;
        bus_out_d = addr_of(k_d);
      end
      S_DAT_WR, S_DAT_HOLD: begin
        cs_n_d    = 1'b0;
        wr_n_d    = (state_d == S_DAT_HOLD);
        a_d_d     = 1'b1;
        bus_oe_d  = 1'b1;
        case (k_d)
          2'd0:    bus_out_d = dia_d;
          2'd1:    bus_out_d = mes_d;
          default: bus_out_d = anio_d;
        endcase
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= 2'd0;
      dia_q     <= 8'h00;
      mes_q     <= 8'h00;
      anio_q    <= 8'h00;
      err_q     <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b0;
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      dia_q     <= dia_d;
      mes_q     <= mes_d;
      anio_q    <= anio_d;
      err_q     <= err_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= 1'b1;
      wr_n_q    <= wr_n_d;
      a_d_q     <= a_d_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
    end
  end

  assign ocupado     = ocupado_q;
  assign listo       = listo_q;
  assign error_dato  = err_q;
  assign rtc.cs_n    = cs_n_q;
  assign rtc.rd_n    = rd_n_q;
  assign rtc.wr_n    = wr_n_q;
  assign rtc.a_d     = a_d_q;
  assign rtc.bus_out = bus_out_q;
  assign rtc.bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_rtc_escritor_fecha.sv
// Bench for rtc_escritor_fecha: a default instance (T_PH=10, T_GAP=5) and a
// short instance (T_PH=2, T_GAP=1), each checked every cycle against a model
// that derives the bus waveform from elapsed cycles since the accepted start.
module tb_rtc_escritor_fecha;

  logic clk;
  logic reset;
  logic       start_s [2];
  logic [7:0] dia_s   [2];
  logic [7:0] mes_s   [2];
  logic [7:0] anio_s  [2];
  logic       oc_a [2], listo_a [2], err_a [2];
  logic       cs_a [2], rd_a [2], wr_a [2], ad_a [2], oe_a [2];
  logic [7:0] bus_a [2];

  rtc_escritor_fecha_if if0 ();
  rtc_escritor_fecha_if if1 ();

  rtc_escritor_fecha dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .dia_bcd(dia_s[0]), .mes_bcd(mes_s[0]), .anio_bcd(anio_s[0]),
    .ocupado(oc_a[0]), .listo(listo_a[0]), .error_dato(err_a[0]),
    .rtc(if0)
  );

  rtc_escritor_fecha #(.T_PH(2), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .dia_bcd(dia_s[1]), .mes_bcd(mes_s[1]), .anio_bcd(anio_s[1]),
    .ocupado(oc_a[1]), .listo(listo_a[1]), .error_dato(err_a[1]),
    .rtc(if1)
  );

  assign cs_a[0] = if0.cs_n;  assign cs_a[1] = if1.cs_n;
  assign rd_a[0] = if0.rd_n;  assign rd_a[1] = if1.rd_n;
  assign wr_a[0] = if0.wr_n;  assign wr_a[1] = if1.wr_n;
  assign ad_a[0] = if0.a_d;   assign ad_a[1] = if1.a_d;
  assign oe_a[0] = if0.bus_oe; assign oe_a[1] = if1.bus_oe;
  assign bus_a[0] = if0.bus_out; assign bus_a[1] = if1.bus_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int ph_of(input int d);
    return (d == 0) ? 10 : 2;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 5 : 1;
  endfunction

  function automatic bit fld_ok(input logic [7:0] b, input int lo, input int hi);
    int t;
    int u;
    int v;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9) return 1'b0;
    v = t * 10 + u;
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] t;
    logic [7:0] u;
    t = 8'(v / 10);
    u = 8'(v % 10);
    return (t << 4) | u;
  endfunction

  // Mostly legal values, sometimes an arbitrary byte.
  function automatic logic [7:0] rand_fld(input int lo, input int hi);
    if ($urandom_range(0, 4) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(lo, hi)));
  endfunction

  // Behavioural model state per instance.
  bit         m_busy [2];
  bit         m_ok   [2];
  bit         m_err  [2];
  int         m_j    [2];
  logic [7:0] m_f    [2][3];
  logic [7:0] m_addr [3] = '{8'h24, 8'h25, 8'h26};

  // Compare on the falling edge, then predict what the next rising edge does.
  initial begin
    forever begin
      int ph, gap, per, total, t, k, r, rr;
      logic e_cs, e_wr, e_ad, e_oe, e_listo;
      logic [7:0] e_bus;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ph = ph_of(d);
        gap = gap_of(d);
        per = 2 * (ph + gap);
        total = 2 + 3 * per;
        if (reset) begin
          m_busy[d] = 1'b0;
          m_err[d] = 1'b0;
          m_j[d] = 0;
        end
        e_cs = 1'b1; e_wr = 1'b1; e_ad = 1'b0; e_oe = 1'b0; e_bus = 8'h00;
        e_listo = m_busy[d] && (m_j[d] == total - 1);
        if (m_busy[d] && m_ok[d] && m_j[d] >= 1 && m_j[d] <= total - 2) begin
          t = m_j[d] - 1;
          k = t / per;
          r = t % per;
          e_cs = 1'b0;
          e_oe = 1'b1;
          e_ad = (r >= ph + gap);
          rr = r % (ph + gap);
          e_wr = (rr >= ph);
          e_bus = e_ad ? m_f[d][k] : m_addr[k];
        end
        chk($sformatf("d%0d ocupado", d), 32'(oc_a[d]), 32'(m_busy[d]));
        chk($sformatf("d%0d listo", d), 32'(listo_a[d]), 32'(e_listo));
        chk($sformatf("d%0d error_dato", d), 32'(err_a[d]), 32'(m_err[d]));
        chk($sformatf("d%0d cs_n", d), 32'(cs_a[d]), 32'(e_cs));
        chk($sformatf("d%0d rd_n", d), 32'(rd_a[d]), 32'h1);
        chk($sformatf("d%0d wr_n", d), 32'(wr_a[d]), 32'(e_wr));
        chk($sformatf("d%0d a_d", d), 32'(ad_a[d]), 32'(e_ad));
        chk($sformatf("d%0d bus_oe", d), 32'(oe_a[d]), 32'(e_oe));
        chk($sformatf("d%0d bus_out", d), 32'(bus_a[d]), 32'(e_bus));
        if (!reset) begin
          if (!m_busy[d]) begin
            if (start_s[d] === 1'b1) begin
              m_busy[d] = 1'b1;
              m_j[d] = 0;
              m_err[d] = 1'b0;
              m_f[d][0] = dia_s[d];
              m_f[d][1] = mes_s[d];
              m_f[d][2] = anio_s[d];
              m_ok[d] = fld_ok(dia_s[d], 1, 31) && fld_ok(mes_s[d], 1, 12) &&
                        fld_ok(anio_s[d], 0, 99);
            end
          end else begin
            m_j[d]++;
            if (!m_ok[d]) begin
              m_busy[d] = 1'b0;
              m_err[d] = 1'b1;
            end else if (m_j[d] == total) begin
              m_busy[d] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Per-transaction measurements.
  int oc_cnt, listo_idx, listo_n, cs_lo, lo_min, lo_max, hi_min, hi_max;
  logic err_at0, err_end;
  logic [7:0] cap [$];

  task automatic run_txn(input int d, input logic [7:0] di, input logic [7:0] me,
                         input logic [7:0] an, input bit disturb);
    int n, lo_run, hi_run;
    bit prev_wr, seen_lo, done;
    @(posedge clk); #1;
    dia_s[d] = di; mes_s[d] = me; anio_s[d] = an; start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    oc_cnt = 0; listo_idx = -1; listo_n = 0; cs_lo = 0;
    lo_min = 1000; lo_max = 0; hi_min = 1000; hi_max = 0;
    lo_run = 0; hi_run = 0; prev_wr = 1'b1; seen_lo = 1'b0; done = 1'b0;
    cap.delete();
    n = 0;
    while (n < 400 && !done) begin
      @(negedge clk);
      if (n == 0) err_at0 = err_a[d];
      if (!oc_a[d]) begin
        done = 1'b1;
      end else begin
        oc_cnt++;
        if (listo_a[d]) begin listo_n++; listo_idx = n; end
        if (!cs_a[d]) cs_lo++;
        if (!wr_a[d]) begin
          if (prev_wr) cap.push_back(bus_a[d]);
          if (hi_run > 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
          end
          hi_run = 0; lo_run++; seen_lo = 1'b1;
        end else begin
          if (lo_run > 0) begin
            if (lo_run < lo_min) lo_min = lo_run;
            if (lo_run > lo_max) lo_max = lo_run;
          end
          lo_run = 0;
          if (!cs_a[d] && seen_lo) hi_run++;
          else if (hi_run > 0) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
          end
        end
        prev_wr = wr_a[d];
        if (disturb && n == 39) begin
          @(posedge clk); #1;
          mes_s[d] = 8'h03; start_s[d] = 1'b1;
        end
        if (disturb && n == 40) begin
          @(posedge clk); #1;
          start_s[d] = 1'b0;
        end
        n++;
      end
    end
    err_end = err_a[d];
    chk("txn completes within bound", 32'(done), 32'h1);
  endtask

  task automatic chk_seq(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    logic [7:0] e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    chk("strobe count", 32'(cap.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < cap.size()) chk($sformatf("strobe %0d value", i), 32'(cap[i]), 32'(e[i]));
  endtask

  task automatic chk_timing(input int oc, input int li, input int lo, input int hi, input int csl);
    chk("ocupado cycles", 32'(oc_cnt), 32'(oc));
    chk("listo index", 32'(listo_idx), 32'(li));
    chk("listo count", 32'(listo_n), 32'd1);
    chk("wr_n low min", 32'(lo_min), 32'(lo));
    chk("wr_n low max", 32'(lo_max), 32'(lo));
    chk("wr_n high min", 32'(hi_min), 32'(hi));
    chk("wr_n high max", 32'(hi_max), 32'(hi));
    chk("cs_n low cycles", 32'(cs_lo), 32'(csl));
    chk("error_dato after accept", 32'(err_at0), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; dia_s[d] = 8'h00; mes_s[d] = 8'h00; anio_s[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cs_n", 32'(if0.cs_n), 32'h1);
    chk("reset wr_n", 32'(if0.wr_n), 32'h1);
    chk("reset bus_oe", 32'(if0.bus_oe), 32'h0);
    chk("reset ocupado", 32'(oc_a[0]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Nominal write.
    run_txn(0, 8'h15, 8'h12, 8'h17, 1'b0);
    chk_timing(92, 91, 10, 5, 90);
    chk_seq(8'h24, 8'h15, 8'h25, 8'h12, 8'h26, 8'h17);

    // Invalid requests: one busy cycle, flag set, bus untouched.
    run_txn(0, 8'h15, 8'h13, 8'h17, 1'b0);
    chk("bad month 13 ocupado", 32'(oc_cnt), 32'd1);
    chk("bad month 13 error", 32'(err_end), 32'h1);
    chk("bad month 13 cs_n", 32'(cs_lo), 32'd0);
    run_txn(0, 8'h15, 8'h00, 8'h17, 1'b0);
    chk("bad month 00 error", 32'(err_end), 32'h1);
    chk("bad month 00 listo", 32'(listo_n), 32'd0);
    run_txn(0, 8'h1A, 8'h05, 8'h17, 1'b0);
    chk("bad day 1A error", 32'(err_end), 32'h1);
    chk("bad day 1A cs_n", 32'(cs_lo), 32'd0);

    // Valid after error, with input change and ignored start at cycle 40.
    run_txn(0, 8'h15, 8'h12, 8'h17, 1'b1);
    chk_timing(92, 91, 10, 5, 90);
    chk_seq(8'h24, 8'h15, 8'h25, 8'h12, 8'h26, 8'h17);

    // Reset during the month data strobe.
    @(posedge clk); #1;
    dia_s[0] = 8'h15; mes_s[0] = 8'h12; anio_s[0] = 8'h17; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (49) @(negedge clk);
    chk("month data bus", 32'(if0.bus_out), 32'h12);
    chk("month data a_d", 32'(if0.a_d), 32'h1);
    chk("month data wr_n", 32'(if0.wr_n), 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async reset cs_n", 32'(if0.cs_n), 32'h1);
    chk("async reset wr_n", 32'(if0.wr_n), 32'h1);
    chk("async reset bus_oe", 32'(if0.bus_oe), 32'h0);
    chk("async reset ocupado", 32'(oc_a[0]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_txn(0, 8'h31, 8'h01, 8'h99, 1'b0);
    chk_timing(92, 91, 10, 5, 90);
    chk_seq(8'h24, 8'h31, 8'h25, 8'h01, 8'h26, 8'h99);

    // Short-timing instance.
    run_txn(1, 8'h07, 8'h09, 8'h24, 1'b0);
    chk_timing(20, 19, 2, 1, 18);
    chk_seq(8'h24, 8'h07, 8'h25, 8'h09, 8'h26, 8'h24);

    // Random traffic on both instances, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        start_s[d] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) begin
          dia_s[d] = rand_fld(0, 31);
          mes_s[d] = rand_fld(0, 12);
          anio_s[d] = rand_fld(0, 99);
        end
      end
    end
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
